jk_reg_bank: RTL
================

JK_REG_BANK -- requirements
Module: jk_reg_bank

Interface
REQ-001 Parameter WIDTH, default 8: number of JK register bits; the block SHALL support any WIDTH from 1 to 32.
REQ-002 Parameter RESET_VAL, default 0: WIDTH-bit value loaded into q on reset.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge only.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 en  input  1  operation enable; low SHALL hold all state except when load=1.
REQ-006 mode  input  2  00 JK per-bit, 01 count up, 10 shift left, 11 count down.
REQ-007 j  input  WIDTH  per-bit J inputs, used in mode 00 only.
REQ-008 k  input  WIDTH  per-bit K inputs, used in mode 00 only.
REQ-009 load  input  1  synchronous parallel load of d.
REQ-010 d  input  WIDTH  parallel load data.
REQ-011 ser_in  input  1  serial input shifted into bit 0 in mode 10.
REQ-012 q  output  WIDTH  register state.
REQ-013 qn  output  WIDTH  bitwise complement of q.
REQ-014 tc  output  1  terminal count, combinational.
REQ-015 changed  output  1  registered flag, high for one cycle after any q bit changed.

Function
REQ-016 Priority at each rising edge SHALL be: load, then en with mode, then hold.
REQ-017 load=1 SHALL set q<=d regardless of en and mode.
REQ-018 Mode 00, en=1: per bit i, (j,k)=00 hold, 01 clear, 10 set, 11 toggle.
REQ-019 Mode 01, en=1: q<=q+1 modulo 2^WIDTH; all-ones SHALL wrap to 0.
REQ-020 Mode 11, en=1: q<=q-1 modulo 2^WIDTH; 0 SHALL wrap to all-ones.
REQ-021 Mode 10, en=1: q<={q[WIDTH-2:0],ser_in}; MSB discarded; for WIDTH=1, q<=ser_in.
REQ-022 Counting SHALL be synchronous; every bit SHALL update on the same edge with no ripple.
REQ-023 tc SHALL be 1 when en=1 and either mode=01 with q all-ones, or mode=11 with q=0; otherwise 0.
REQ-024 tc SHALL be 0 whenever load=1.
REQ-025 changed SHALL be 1 in the cycle following any edge at which q's next value differed from its current value; else 0.
REQ-026 A load of a value equal to the current q SHALL NOT set changed.
REQ-027 j and k SHALL be ignored in modes 01, 10 and 11; ser_in SHALL be ignored outside mode 10.
REQ-028 A mode change SHALL take effect on the first edge after it is applied; no pipeline latency.
REQ-029 qn SHALL equal ~q at all times, including during reset.

Reset
REQ-030 rst=1 SHALL immediately, without waiting for clk, force q=RESET_VAL, qn=~RESET_VAL and changed=0.
REQ-031 While rst=1, load, en and all data inputs SHALL be ignored.
REQ-032 Reset deassertion SHALL NOT itself set changed; the first active edge after release SHALL operate normally.
REQ-033 Reset asserted mid-count or mid-shift SHALL discard the operation in progress with no residual state.

Verification (WIDTH=4, RESET_VAL=0)
REQ-034 JK truth table: mode 00, en=1, j=4'b0110, k=4'b0101, q=4'b0011 -> next q=4'b0110, changed=1 one cycle later.
REQ-035 Up-count wrap: load d=4'hE, then mode 01, en=1 for 3 edges -> q=F (tc=1), then 0, then 1.
REQ-036 Down-count wrap: q=1, mode 11, en=1 for 2 edges -> q=0 (tc=1), then F (tc=0); en=0 -> q holds F, changed=0.
REQ-037 Shift: q=4'b1001, mode 10, ser_in sequence 1,0,1 -> q=0011, 0110, 1101.
REQ-038 Priority and hold: load=1, d=A, en=0 -> q=A; load=0, en=0, j=k=F -> q stays A for 3 cycles, changed=0.
REQ-039 Asynchronous reset: rst pulsed between edges during mode 01 at q=7 -> q=0 and qn=F before the next edge; the first edge after release gives q=1.

Source files
------------

// File: rtl/jk_reg_bank.sv
// Bank of WIDTH JK flip-flops. It also supports synchronous up/down counting, shift-left and parallel load.
// tc is combinational; changed is a registered flag that marks any q transition.
module jk_reg_bank #(
    parameter int                WIDTH     = 8,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             tc,
    output logic             changed
);

    localparam logic [1:0] MODE_JK    = 2'b00;
    localparam logic [1:0] MODE_UP    = 2'b01;
    localparam logic [1:0] MODE_SHIFT = 2'b10;
    localparam logic [1:0] MODE_DOWN  = 2'b11;

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic             changed_reg;
    logic [WIDTH-1:0] jk_next;
    logic [WIDTH-1:0] shift_next;

    // Per-bit JK behaviour: 00 hold, 01 clear, 10 set, 11 toggle.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_jk
            assign jk_next[gi] = j[gi] ? (k[gi] ? ~q_reg[gi] : 1'b1)
                                       : (k[gi] ? 1'b0 : q_reg[gi]);
        end
        if (WIDTH == 1) begin : g_shift_one
            assign shift_next = ser_in;
        end else begin : g_shift_wide
            assign shift_next = {q_reg[WIDTH-2:0], ser_in};
        end
    endgenerate

    always_comb begin
        q_next = q_reg;
        if (load) begin
            q_next = d;
        end else if (en) begin
            case (mode)
                MODE_JK:    q_next = jk_next;
                MODE_UP:    q_next = q_reg + WIDTH'(1);
                MODE_SHIFT: q_next = shift_next;
                MODE_DOWN:  q_next = q_reg - WIDTH'(1);
                default:    q_next = q_reg;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg       <= RESET_VAL;
            changed_reg <= 1'b0;
        end else begin
            q_reg       <= q_next;
            changed_reg <= (q_next != q_reg);
        end
    end

    // Terminal count looks at the operation about to happen, so a pending load masks it.
    assign tc = en && !load &&
                (((mode == MODE_UP) && (&q_reg)) || ((mode == MODE_DOWN) && (~|q_reg)));

    assign q       = q_reg;
    assign qn      = ~q_reg;
    assign changed = changed_reg;

endmodule
